// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller: forwarding mux
// select codes, MDU sequencer state encoding and a register-match helper.
package hazard_pkg;

  // Forwarding mux select codes for the E-stage operand muxes
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  // MDU sequencer state encoding
  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mdu_state_e;

  // True when a producer destination feeds a consumer source.
  // Register 0 is hard-wired to zero and never creates a dependency.
  function automatic logic reg_hit(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_mdu_seq.sv
// mdu_seq: tracks a multi-cycle multiply/divide operation. It is started by
// MduStartE in E and reports MduBusy for exactly MDU_LAT-1 cycles after the
// start edge, so that HI/LO consumers in Decode can be held until completion.
module mdu_seq
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 8
) (
  input  logic CLK,
  input  logic RST,
  input  logic MduStartE,
  output logic MduBusy
);

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q;

  // Next-state: load remaining busy cycles on start, count down while busy.
  // A start while busy cannot legally happen and is ignored.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (MduStartE) begin
          cnt_d   = CNT_W'(MDU_LAT - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State, counter and registered busy flag; reset abandons any operation
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= (state_d == BUSY);
    end
  end

  assign MduBusy = busy_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush/forwarding control for the 5-stage
// MIPS32 pipeline, plus sequencing of the multi-cycle MDU via mdu_seq.
// Optional macro HAZARD_STATS_EN adds saturating 32-bit StallCnt, FlushCnt
// and MduStallCnt event counters.
//
// There is no valid/ready handshake here: every output is a same-cycle
// function of the stage inputs and the MDU busy state, and a stall freezes F
// and D while E receives a bubble.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MDU_LAT = 32,
  parameter int CNT_W   = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [4:0] RsD,
  input  logic [4:0] RtD,
  input  logic [4:0] RsE,
  input  logic [4:0] RtE,
  input  logic [4:0] WriteRegE,
  input  logic [4:0] WriteRegM,
  input  logic [4:0] WriteRegW,
  input  logic       RegWriteE,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       MemtoRegM,
  input  logic       BranchD,
  input  logic       JumpRegD,
  input  logic       PCSrcD,
  input  logic       MduStartE,
  input  logic       MduUseD,
  output logic       StallF,
  output logic       EnableD,
  output logic       RstD,
  output logic       FlushE,
  output logic       ForwardAD,
  output logic       ForwardBD,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       MduBusy
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt,
  output logic [31:0] MduStallCnt
`endif
);

  logic mdu_busy;
  logic lwstall, brstall, mdustall, stall;
  logic fwd_ad, fwd_bd;
  logic [1:0] fwd_ae, fwd_be;

  mdu_seq #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) u_mdu_seq (
    .CLK       (CLK),
    .RST       (RST),
    .MduStartE (MduStartE),
    .MduBusy   (mdu_busy)
  );

  // Forwarding selects (M has priority over W) and stall detection
  always_comb begin
    fwd_ae = FWD_RF;
    if (RegWriteM && reg_hit(WriteRegM, RsE))      fwd_ae = FWD_M;
    else if (RegWriteW && reg_hit(WriteRegW, RsE)) fwd_ae = FWD_W;

    fwd_be = FWD_RF;
    if (RegWriteM && reg_hit(WriteRegM, RtE))      fwd_be = FWD_M;
    else if (RegWriteW && reg_hit(WriteRegW, RtE)) fwd_be = FWD_W;

    fwd_ad = RegWriteM && reg_hit(WriteRegM, RsD);
    fwd_bd = RegWriteM && reg_hit(WriteRegM, RtD);

    lwstall = MemtoRegE && (reg_hit(WriteRegE, RsD) || reg_hit(WriteRegE, RtD));

    // JR/JALR only reads Rs; branches compare both Rs and Rt in D
    brstall = (BranchD || JumpRegD) &&
              ((RegWriteE && (reg_hit(WriteRegE, RsD) ||
                              (BranchD && reg_hit(WriteRegE, RtD)))) ||
               (MemtoRegM && (reg_hit(WriteRegM, RsD) ||
                              (BranchD && reg_hit(WriteRegM, RtD)))));

    mdustall = MduUseD && mdu_busy;
    stall    = lwstall || brstall || mdustall;
  end

  // Output drive; reset forces a flushed, non-stalled pipeline.
  // A stall masks PCSrcD because the branch operands are not yet valid.
  always_comb begin
    StallF    = 1'b0;
    EnableD   = 1'b1;
    RstD      = 1'b1;
    FlushE    = 1'b1;
    ForwardAD = 1'b0;
    ForwardBD = 1'b0;
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    MduBusy   = 1'b0;
    if (!RST) begin
      StallF    = stall;
      EnableD   = ~stall;
      RstD      = PCSrcD && ~stall;
      FlushE    = stall;
      ForwardAD = fwd_ad;
      ForwardBD = fwd_bd;
      ForwardAE = fwd_ae;
      ForwardBE = fwd_be;
      MduBusy   = mdu_busy;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;
  logic [31:0] mdu_stall_cnt_q, mdu_stall_cnt_d;

  // Saturating event counter increments
  always_comb begin
    stall_cnt_d     = stall_cnt_q;
    flush_cnt_d     = flush_cnt_q;
    mdu_stall_cnt_d = mdu_stall_cnt_q;
    if (stall && (stall_cnt_q != '1))                 stall_cnt_d     = stall_cnt_q + 32'd1;
    if (PCSrcD && !stall && (flush_cnt_q != '1))      flush_cnt_d     = flush_cnt_q + 32'd1;
    if (mdustall && (mdu_stall_cnt_q != '1))          mdu_stall_cnt_d = mdu_stall_cnt_q + 32'd1;
  end

  // Counter registers, cleared by reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      stall_cnt_q     <= '0;
      flush_cnt_q     <= '0;
      mdu_stall_cnt_q <= '0;
    end else begin
      stall_cnt_q     <= stall_cnt_d;
      flush_cnt_q     <= flush_cnt_d;
      mdu_stall_cnt_q <= mdu_stall_cnt_d;
    end
  end

  assign StallCnt    = stall_cnt_q;
  assign FlushCnt    = flush_cnt_q;
  assign MduStallCnt = mdu_stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl with MDU_LAT=4. Each vector pushes
// a hand-computed expected output word; a negedge monitor pops and compares.
module tb_pipeline_hazard_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs_d, rt_d, rs_e, rt_e, wr_e, wr_m, wr_w;
  logic       rw_e, rw_m, rw_w, m2r_e, m2r_m, br_d, jr_d, pcsrc_d, mdu_start, mdu_use;
  logic       stall_f, en_d, rst_d, flush_e, fad, fbd, busy;
  logic [1:0] fae, fbe;
`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt, flush_cnt, mdu_stall_cnt;
`endif

  pipeline_hazard_ctrl #(.MDU_LAT(4), .CNT_W(8)) dut (
    .CLK(clk), .RST(rst),
    .RsD(rs_d), .RtD(rt_d), .RsE(rs_e), .RtE(rt_e),
    .WriteRegE(wr_e), .WriteRegM(wr_m), .WriteRegW(wr_w),
    .RegWriteE(rw_e), .RegWriteM(rw_m), .RegWriteW(rw_w),
    .MemtoRegE(m2r_e), .MemtoRegM(m2r_m),
    .BranchD(br_d), .JumpRegD(jr_d), .PCSrcD(pcsrc_d),
    .MduStartE(mdu_start), .MduUseD(mdu_use),
    .StallF(stall_f), .EnableD(en_d), .RstD(rst_d), .FlushE(flush_e),
    .ForwardAD(fad), .ForwardBD(fbd), .ForwardAE(fae), .ForwardBE(fbe),
    .MduBusy(busy)
`ifdef HAZARD_STATS_EN
    , .StallCnt(stall_cnt), .FlushCnt(flush_cnt), .MduStallCnt(mdu_stall_cnt)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [10:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  // Output word: {StallF,EnableD,RstD,FlushE,ForwardAD,ForwardBD,ForwardAE,ForwardBE,MduBusy}
  function automatic logic [10:0] ev(input logic sf, input logic ed, input logic rd,
                                     input logic fe, input logic ad, input logic bd,
                                     input logic [1:0] ae, input logic [1:0] be,
                                     input logic mb);
    return {sf, ed, rd, fe, ad, bd, ae, be, mb};
  endfunction

  localparam logic [10:0] V_IDLE  = 11'b0100_00_00_00_0;
  localparam logic [10:0] V_RST   = 11'b0111_00_00_00_0;
  localparam logic [10:0] V_STALL = 11'b1001_00_00_00_0;

  // Monitor: compare the DUT output word mid-cycle against the oldest expectation
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      logic [10:0] e, a;
      string       nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = {stall_f, en_d, rst_d, flush_e, fad, fbd, fae, fbe, busy};
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %b expected %b (StallF,EnableD,RstD,FlushE,FAD,FBD,FAE,FBE,Busy)",
                 nm, a, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clr_in();
    rst = 1'b0; rs_d = '0; rt_d = '0; rs_e = '0; rt_e = '0;
    wr_e = '0; wr_m = '0; wr_w = '0; rw_e = 1'b0; rw_m = 1'b0; rw_w = 1'b0;
    m2r_e = 1'b0; m2r_m = 1'b0; br_d = 1'b0; jr_d = 1'b0; pcsrc_d = 1'b0;
    mdu_start = 1'b0; mdu_use = 1'b0;
  endtask

  // Issue the currently applied inputs for one cycle with its expectation
  task automatic vec(input string nm, input logic [10:0] e);
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

`ifdef HAZARD_STATS_EN
  task automatic chk32(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_checks++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin
    clr_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset: outputs forced even with hazards present on the inputs
    vec("reset_idle", V_RST);
    rs_e = 5'd3; wr_m = 5'd3; rw_m = 1'b1; m2r_e = 1'b1; wr_e = 5'd5; rt_d = 5'd5; mdu_use = 1'b1;
    vec("reset_forced", V_RST);
    clr_in();
    vec("post_reset_idle", V_IDLE);

    // E-stage forwarding
    rs_e = 5'd3; wr_m = 5'd3; rw_m = 1'b1; wr_w = 5'd3; rw_w = 1'b1;
    vec("fwd_ae_m_priority", ev(0, 1, 0, 0, 0, 0, 2'b10, 2'b00, 0));
    rw_m = 1'b0;
    vec("fwd_ae_w", ev(0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 0));
    clr_in(); rs_e = 5'd0; wr_m = 5'd0; rw_m = 1'b1; wr_w = 5'd0; rw_w = 1'b1;
    vec("fwd_ae_r0", V_IDLE);
    clr_in(); rs_e = 5'd4; rt_e = 5'd9; wr_m = 5'd4; rw_m = 1'b1; wr_w = 5'd9; rw_w = 1'b1;
    rs_d = 5'd4; rt_d = 5'd9;
    vec("fwd_be_w_ad_m", ev(0, 1, 0, 0, 1, 0, 2'b10, 2'b01, 0));

    // Load-use stall, then release once the load is in M
    clr_in(); m2r_e = 1'b1; rw_e = 1'b1; wr_e = 5'd5; rt_d = 5'd5;
    vec("lwstall", V_STALL);
    clr_in(); m2r_m = 1'b1; rw_m = 1'b1; wr_m = 5'd5; rt_d = 5'd5;
    vec("lw_release_fbd", ev(0, 1, 0, 0, 0, 1, 2'b00, 2'b00, 0));
    clr_in(); m2r_e = 1'b1; rw_e = 1'b1; wr_e = 5'd0;
    vec("lwstall_r0", V_IDLE);

    // Branch stall masks PCSrcD, then flush once resolved
    clr_in(); br_d = 1'b1; rs_d = 5'd7; rw_e = 1'b1; wr_e = 5'd7; pcsrc_d = 1'b1;
    vec("brstall_e", V_STALL);
    clr_in(); br_d = 1'b1; rs_d = 5'd7; rw_m = 1'b1; wr_m = 5'd7; pcsrc_d = 1'b1;
    vec("br_resolved_flush", ev(0, 1, 1, 0, 1, 0, 2'b00, 2'b00, 0));
    clr_in(); br_d = 1'b1; rt_d = 5'd6; m2r_m = 1'b1; rw_m = 1'b1; wr_m = 5'd6;
    vec("brstall_load_m_rt", ev(1, 0, 0, 1, 0, 1, 2'b00, 2'b00, 0));
    clr_in(); jr_d = 1'b1; rs_d = 5'd2; rt_d = 5'd8; rw_e = 1'b1; wr_e = 5'd8; pcsrc_d = 1'b1;
    vec("jr_ignores_rt", ev(0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0));
    clr_in(); jr_d = 1'b1; rs_d = 5'd8; rw_e = 1'b1; wr_e = 5'd8; pcsrc_d = 1'b1;
    vec("jr_stall_rs", V_STALL);

    // MDU: busy exactly 3 cycles with MDU_LAT=4, HI/LO user stalls throughout
    clr_in(); mdu_start = 1'b1;
    vec("mdu_start", V_IDLE);
    clr_in(); mdu_use = 1'b1;
    vec("mdu_busy1", ev(1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1));
    pcsrc_d = 1'b1;
    vec("mdu_busy2_pcsrc", ev(1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1));
    pcsrc_d = 1'b0;
    vec("mdu_busy3", ev(1, 0, 0, 1, 0, 0, 2'b00, 2'b00, 1));
    vec("mdu_done_release", V_IDLE);
    vec("mdu_stays_idle", V_IDLE);

    // Reset in the 2nd busy cycle abandons the operation
    clr_in(); mdu_start = 1'b1;
    vec("mdu2_start", V_IDLE);
    clr_in();
    vec("mdu2_busy1", ev(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1));
    rst = 1'b1; mdu_use = 1'b1;
    vec("mdu2_reset", V_RST);
    rst = 1'b0;
    vec("mdu2_after_reset", V_IDLE);
    vec("mdu2_no_residue", V_IDLE);

    // A fresh operation after reset still runs its full length
    clr_in(); mdu_start = 1'b1;
    vec("mdu3_start", V_IDLE);
    clr_in();
    vec("mdu3_busy1", ev(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1));
    vec("mdu3_busy2", ev(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1));
    vec("mdu3_busy3", ev(0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 1));
    vec("mdu3_done", V_IDLE);

`ifdef HAZARD_STATS_EN
    clr_in(); rst = 1'b1;
    vec("stats_reset", V_RST);
    clr_in(); m2r_e = 1'b1; wr_e = 5'd5; rt_d = 5'd5;
    for (int i = 0; i < 3; i++) vec("stats_lwstall", V_STALL);
    clr_in(); pcsrc_d = 1'b1;
    vec("stats_flush", ev(0, 1, 1, 0, 0, 0, 2'b00, 2'b00, 0));
    clr_in();
    chk32("stall_cnt", stall_cnt, 32'd3);
    chk32("flush_cnt", flush_cnt, 32'd1);
    chk32("mdu_stall_cnt", mdu_stall_cnt, 32'd0);
    rst = 1'b1;
    vec("stats_reset2", V_RST);
    rst = 1'b0;
    chk32("stall_cnt_clr", stall_cnt, 32'd0);
    chk32("flush_cnt_clr", flush_cnt, 32'd0);
`endif

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
